cpu_bmu: RTL and testbench
==========================

CPU_BMU -- requirements
Module: cpu_bmu

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: operand_a  input  XLEN  signed first source operand (rs1).
REQ-005 Port: operand_b  input  XLEN  second source operand (rs2 or immediate).
REQ-006 Port: control  input  6  operation select; encodings per REQ-008.
REQ-007 Port: result  output  XLEN  registered operation result.

Function
REQ-008 Encodings SHALL be: ANDN=0, ORN=1, XNOR=2, CLZ=3, CTZ=4, CPOP=5, MAX=6, MAXU=7, MIN=8, MINU=9, SEXT_B=10, SEXT_H=11, ZEXT_H=12, ROL=13, ROR=14, ORC_B=15, REV8=16, BCLR=17, BEXT=18, BINV=19, BSET=20.
REQ-009 Next-result logic SHALL be purely combinational from operand_a, operand_b and control.
REQ-010 result SHALL register the next-result value on every rising clk edge: latency exactly 1 cycle, no handshake, new operation accepted every cycle.
REQ-011 ANDN = a & ~b; ORN = a | ~b; XNOR = ~(a ^ b).
REQ-012 CLZ/CTZ SHALL count leading/trailing zeros of a over XLEN bits; a=0 yields XLEN.
REQ-013 CPOP SHALL count set bits of a; count zero-extended to XLEN.
REQ-014 MAX/MIN SHALL compare signed, MAXU/MINU unsigned; equal operands return a.
REQ-015 SEXT_B/SEXT_H SHALL sign-extend a[7:0]/a[15:0]; ZEXT_H SHALL zero-extend a[15:0].
REQ-016 ROL/ROR SHALL rotate a by b[log2(XLEN)-1:0]; upper bits of b ignored; shift 0 returns a.
REQ-017 ORC_B SHALL set each byte to 0xFF if any bit in it is set, else 0x00; REV8 SHALL reverse byte order over XLEN.
REQ-018 BCLR/BINV/BSET SHALL clear/invert/set bit b[log2(XLEN)-1:0] of a; BEXT SHALL return that bit in bit 0, upper bits zero.
REQ-019 Any unlisted control value SHALL produce next result 0.

Reset
REQ-020 While rst_n is low, result SHALL be 0 immediately (asynchronous), irrespective of clk.
REQ-021 After rst_n deasserts, the first rising edge SHALL load the then-current operation's result; no further state exists.

Configuration
REQ-022 Macro BMU_ZBS_EN: when defined, BCLR/BEXT/BINV/BSET are implemented per REQ-018; when undefined, those encodings SHALL behave as unlisted (result 0) and their logic SHALL be absent.

Structure
REQ-023 The control encodings (REQ-008) and control width SHALL reside in a shared package (cpu_pkg) used by the decoder and this block.
REQ-024 Leading/trailing-zero counting SHALL be one sub-module, cpu_bmu_lzc (parameterised by XLEN; CTZ uses it on bit-reversed a).

Verification
REQ-025 XLEN=32: CLZ a=0x00000006 -> 29 (0x1D); XLEN=64 same input -> 61, and a=0x6E -> 57.
REQ-026 CTZ a=0x0F000020 -> 5; XLEN=64 CTZ a=0x00F0000000002000 -> 13; CTZ a=0 -> XLEN.
REQ-027 CPOP a=0xF0F0F0F0 -> 16; XLEN=64 CPOP a=0xFFFFFFFF00000000 -> 32.
REQ-028 ANDN a=0xFF00FF00, b=0x00FF00FF -> 0xFF00FF00; ORN same operands (XLEN=32) -> 0xFF00FF00.
REQ-029 ROL a=0x80000000, b=1 -> 0x00000001 (XLEN=32); ROR a=1, b=1 -> MSB only (0x80000000 / 0x8000000000000000); ROR b=33 at XLEN=32 equals ROR b=1.
REQ-030 Reset/latency: drive CPOP a=0xFF with rst_n low -> result 0; release rst_n, one rising edge -> 8; change control to unlisted value -> 0 after next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control width and the bit-manipulation unit operation encodings.
package cpu_pkg;

   localparam int CTRL_W = 6;

   typedef enum logic [CTRL_W-1:0] {
      BMU_ANDN   = 6'd0,
      BMU_ORN    = 6'd1,
      BMU_XNOR   = 6'd2,
      BMU_CLZ    = 6'd3,
      BMU_CTZ    = 6'd4,
      BMU_CPOP   = 6'd5,
      BMU_MAX    = 6'd6,
      BMU_MAXU   = 6'd7,
      BMU_MIN    = 6'd8,
      BMU_MINU   = 6'd9,
      BMU_SEXT_B = 6'd10,
      BMU_SEXT_H = 6'd11,
      BMU_ZEXT_H = 6'd12,
      BMU_ROL    = 6'd13,
      BMU_ROR    = 6'd14,
      BMU_ORC_B  = 6'd15,
      BMU_REV8   = 6'd16,
      BMU_BCLR   = 6'd17,
      BMU_BEXT   = 6'd18,
      BMU_BINV   = 6'd19,
      BMU_BSET   = 6'd20
   } bmu_op_e;

endpackage

// File: rtl/cpu_bmu_lzc.sv
// Leading-zero counter over XLEN bits; all-zero input yields XLEN.
// Latency: combinational. Backpressure: none.
// Flow: pure function of data, no handshake.
module cpu_bmu_lzc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]            data,
   output logic [$clog2(XLEN+1)-1:0]  count
);

   localparam int CW = $clog2(XLEN+1);

   // Scanning upward lets the highest set bit take final priority.
   always_comb begin
      count = CW'(XLEN);
      for (int i = 0; i < XLEN; i++) begin
         if (data[i]) count = CW'(XLEN - 1 - i);
      end
   end

endmodule

// File: rtl/cpu_bmu.sv
// Bit-manipulation unit: combinational op select, result registered. Zbs single-bit ops under BMU_ZBS_EN.
// Latency: 1 cycle. Backpressure: none, a new operation is accepted every cycle.
module cpu_bmu
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   operand_a,
   input  logic [XLEN-1:0]   operand_b,
   input  logic [CTRL_W-1:0] control,
   output logic [XLEN-1:0]   result
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = $clog2(XLEN+1);
   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] a_rev;
   logic [CW-1:0]   clz_cnt;
   logic [CW-1:0]   ctz_cnt;
   logic [CW-1:0]   pop_cnt;
   logic [SW-1:0]   sh;
   logic [SW:0]     sh_inv;
   logic [XLEN-1:0] rol_val;
   logic [XLEN-1:0] ror_val;
   logic [XLEN-1:0] orc_val;
   logic [XLEN-1:0] rev_val;
   logic [XLEN-1:0] nxt;

   always_comb begin
      a_rev = '0;
      for (int i = 0; i < XLEN; i++) a_rev[i] = operand_a[XLEN-1-i];
   end

   cpu_bmu_lzc #(.XLEN(XLEN)) u_clz (.data(operand_a), .count(clz_cnt));
   cpu_bmu_lzc #(.XLEN(XLEN)) u_ctz (.data(a_rev),     .count(ctz_cnt));

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < XLEN; i++) pop_cnt = pop_cnt + CW'(operand_a[i]);
   end

   // sh_inv reaches XLEN when sh is 0, so the wrap-around term shifts out to zero.
   assign sh      = operand_b[SW-1:0];
   assign sh_inv  = (SW+1)'(XLEN) - {1'b0, sh};
   assign rol_val = (operand_a << sh) | (operand_a >> sh_inv);
   assign ror_val = (operand_a >> sh) | (operand_a << sh_inv);

   always_comb begin
      orc_val = '0;
      rev_val = '0;
      for (int i = 0; i < NB; i++) begin
         orc_val[i*8 +: 8] = (|operand_a[i*8 +: 8]) ? 8'hFF : 8'h00;
         rev_val[i*8 +: 8] = operand_a[(NB-1-i)*8 +: 8];
      end
   end

`ifdef BMU_ZBS_EN
   logic [XLEN-1:0] bit_mask;
   assign bit_mask = {{(XLEN-1){1'b0}}, 1'b1} << sh;
`endif

   always_comb begin
      nxt = '0;
      case (control)
         BMU_ANDN:   nxt = operand_a & ~operand_b;
         BMU_ORN:    nxt = operand_a | ~operand_b;
         BMU_XNOR:   nxt = ~(operand_a ^ operand_b);
         BMU_CLZ:    nxt = XLEN'(clz_cnt);
         BMU_CTZ:    nxt = XLEN'(ctz_cnt);
         BMU_CPOP:   nxt = XLEN'(pop_cnt);
         BMU_MAX:    nxt = ($signed(operand_a) >= $signed(operand_b)) ? operand_a : operand_b;
         BMU_MAXU:   nxt = (operand_a >= operand_b) ? operand_a : operand_b;
         BMU_MIN:    nxt = ($signed(operand_a) <= $signed(operand_b)) ? operand_a : operand_b;
         BMU_MINU:   nxt = (operand_a <= operand_b) ? operand_a : operand_b;
         BMU_SEXT_B: nxt = {{(XLEN-8){operand_a[7]}}, operand_a[7:0]};
         BMU_SEXT_H: nxt = {{(XLEN-16){operand_a[15]}}, operand_a[15:0]};
         BMU_ZEXT_H: nxt = {{(XLEN-16){1'b0}}, operand_a[15:0]};
         BMU_ROL:    nxt = rol_val;
         BMU_ROR:    nxt = ror_val;
         BMU_ORC_B:  nxt = orc_val;
         BMU_REV8:   nxt = rev_val;
`ifdef BMU_ZBS_EN
         BMU_BCLR:   nxt = operand_a & ~bit_mask;
         BMU_BEXT:   nxt = {{(XLEN-1){1'b0}}, |(operand_a & bit_mask)};
         BMU_BINV:   nxt = operand_a ^ bit_mask;
         BMU_BSET:   nxt = operand_a | bit_mask;
`endif
         default:    nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) result <= '0;
      else        result <= nxt;
   end

endmodule

// File: tb/tb_cpu_bmu.sv
// Directed bench for cpu_bmu at XLEN=32 and XLEN=64 sharing clock, reset and control.
module tb_cpu_bmu;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  control;
   logic [31:0] a32, b32, r32;
   logic [63:0] a64, b64, r64;
   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   cpu_bmu #(.XLEN(32)) u_bmu32 (
      .clk(clk), .rst_n(rst_n), .operand_a(a32), .operand_b(b32),
      .control(control), .result(r32)
   );

   cpu_bmu #(.XLEN(64)) u_bmu64 (
      .clk(clk), .rst_n(rst_n), .operand_a(a64), .operand_b(b64),
      .control(control), .result(r64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      control = BMU_CPOP;
      a32 = 32'hFF; b32 = '0;
      a64 = 64'hFF; b64 = '0;
      step();
      step();
      tests_run++;
      if (r32 !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset32: got %h expected %h", r32, 32'h0);
      end
      tests_run++;
      if (r64 !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset64: got %h expected %h", r64, 64'h0);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (r32 !== 32'd8) begin
         tests_failed++;
         $display("FAIL first_edge32: got %h expected %h", r32, 32'd8);
      end
      tests_run++;
      if (r64 !== 64'd8) begin
         tests_failed++;
         $display("FAIL first_edge64: got %h expected %h", r64, 64'd8);
      end
      control = 6'd63;
      step();
      tests_run++;
      if (r32 !== 32'h0) begin
         tests_failed++;
         $display("FAIL unlisted_after_reset: got %h expected %h", r32, 32'h0);
      end
   endtask

   task automatic test_logic();
      logic [5:0]  c  [9] = '{BMU_ANDN, BMU_ORN, BMU_XNOR, BMU_MAX, BMU_MAXU,
                              BMU_MIN, BMU_MINU, BMU_MIN, BMU_MAX};
      logic [31:0] va [9] = '{32'hFF00FF00, 32'hFF00FF00, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000};
      logic [31:0] vb [9] = '{32'h00FF00FF, 32'h00FF00FF, 32'hFF00FF00, 32'h00000001, 32'h00000001,
                              32'h00000001, 32'h00000001, 32'h00000005, 32'h7FFFFFFF};
      logic [31:0] ve [9] = '{32'hFF00FF00, 32'hFF00FF00, 32'hF00FF00F, 32'h00000001, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h00000001, 32'h00000005, 32'h7FFFFFFF};
      for (int i = 0; i < 9; i++) begin
         control = c[i]; a32 = va[i]; b32 = vb[i];
         step();
         tests_run++;
         if (r32 !== ve[i]) begin
            tests_failed++;
            $display("FAIL logic[%0d] op=%0d: got %h expected %h", i, c[i], r32, ve[i]);
         end
      end
   endtask

   task automatic test_count();
      logic [5:0]  c  [8] = '{BMU_CLZ, BMU_CLZ, BMU_CLZ, BMU_CTZ, BMU_CTZ,
                              BMU_CPOP, BMU_CPOP, BMU_CPOP};
      logic [31:0] va [8] = '{32'h00000006, 32'h00000000, 32'h80000000, 32'h0F000020, 32'h00000000,
                              32'hF0F0F0F0, 32'h00000000, 32'hFFFFFFFF};
      logic [31:0] ve [8] = '{32'd29, 32'd32, 32'd0, 32'd5, 32'd32, 32'd16, 32'd0, 32'd32};
      b32 = 32'hFFFFFFFF;
      for (int i = 0; i < 8; i++) begin
         control = c[i]; a32 = va[i];
         step();
         tests_run++;
         if (r32 !== ve[i]) begin
            tests_failed++;
            $display("FAIL count[%0d] op=%0d: got %h expected %h", i, c[i], r32, ve[i]);
         end
      end
   endtask

   task automatic test_ext_perm();
      logic [5:0]  c  [12] = '{BMU_SEXT_B, BMU_SEXT_B, BMU_SEXT_H, BMU_ZEXT_H, BMU_ORC_B, BMU_REV8,
                               BMU_ROL, BMU_ROL, BMU_ROR, BMU_ROR, BMU_ROL, BMU_ROR};
      logic [31:0] va [12] = '{32'h00000080, 32'hFFFFFF7F, 32'h00018000, 32'hFFFF8000, 32'h00010080,
                               32'h12345678, 32'h80000000, 32'h12345678, 32'h00000001, 32'h00000001,
                               32'h12345678, 32'h12345678};
      logic [31:0] vb [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'd1, 32'd0, 32'd1, 32'd33, 32'd4, 32'h24};
      logic [31:0] ve [12] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF8000, 32'h00008000, 32'h00FF00FF,
                               32'h78563412, 32'h00000001, 32'h12345678, 32'h80000000, 32'h80000000,
                               32'h23456781, 32'h81234567};
      for (int i = 0; i < 12; i++) begin
         control = c[i]; a32 = va[i]; b32 = vb[i];
         step();
         tests_run++;
         if (r32 !== ve[i]) begin
            tests_failed++;
            $display("FAIL ext_perm[%0d] op=%0d: got %h expected %h", i, c[i], r32, ve[i]);
         end
      end
   endtask

   task automatic test_zbs();
      logic [5:0]  c  [4] = '{BMU_BCLR, BMU_BEXT, BMU_BINV, BMU_BSET};
      logic [31:0] va [4] = '{32'hFFFFFFFF, 32'h00000010, 32'h00000000, 32'h00000000};
      logic [31:0] vb [4] = '{32'h00000023, 32'd4, 32'd31, 32'd5};
`ifdef BMU_ZBS_EN
      logic [31:0] ve [4] = '{32'hFFFFFFF7, 32'h00000001, 32'h80000000, 32'h00000020};
`else
      logic [31:0] ve [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
`endif
      for (int i = 0; i < 4; i++) begin
         control = BMU_CPOP; a32 = 32'hF;
         step();
         control = c[i]; a32 = va[i]; b32 = vb[i];
         step();
         tests_run++;
         if (r32 !== ve[i]) begin
            tests_failed++;
            $display("FAIL zbs[%0d] op=%0d: got %h expected %h", i, c[i], r32, ve[i]);
         end
      end
   endtask

   task automatic test_unlisted();
      logic [5:0] c [3] = '{6'd21, 6'd31, 6'd63};
      for (int i = 0; i < 3; i++) begin
         control = BMU_CPOP; a32 = 32'hFFFFFFFF;
         step();
         control = c[i];
         step();
         tests_run++;
         if (r32 !== 32'h0) begin
            tests_failed++;
            $display("FAIL unlisted[%0d] op=%0d: got %h expected %h", i, c[i], r32, 32'h0);
         end
      end
   endtask

   task automatic test_xlen64();
      logic [5:0]  c  [8] = '{BMU_CLZ, BMU_CLZ, BMU_CTZ, BMU_CTZ, BMU_CPOP, BMU_ROR, BMU_REV8, BMU_ROL};
      logic [63:0] va [8] = '{64'h6, 64'h6E, 64'h00F0000000002000, 64'h0, 64'hFFFFFFFF00000000,
                              64'h1, 64'h0102030405060708, 64'h8000000000000000};
      logic [63:0] vb [8] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'd1, 64'h0, 64'd65};
      logic [63:0] ve [8] = '{64'd61, 64'd57, 64'd13, 64'd64, 64'd32, 64'h8000000000000000,
                              64'h0807060504030201, 64'h1};
      for (int i = 0; i < 8; i++) begin
         control = c[i]; a64 = va[i]; b64 = vb[i];
         step();
         tests_run++;
         if (r64 !== ve[i]) begin
            tests_failed++;
            $display("FAIL xlen64[%0d] op=%0d: got %h expected %h", i, c[i], r64, ve[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      control = BMU_CPOP; a32 = 32'hFF;
      step();
      tests_run++;
      if (r32 !== 32'd8) begin
         tests_failed++;
         $display("FAIL b2b_first: got %h expected %h", r32, 32'd8);
      end
      control = BMU_CLZ; a32 = 32'h1;
      #1;
      tests_run++;
      if (r32 !== 32'd8) begin
         tests_failed++;
         $display("FAIL b2b_hold_before_edge: got %h expected %h", r32, 32'd8);
      end
      step();
      tests_run++;
      if (r32 !== 32'd31) begin
         tests_failed++;
         $display("FAIL b2b_second: got %h expected %h", r32, 32'd31);
      end
   endtask

   task automatic test_async_reset();
      control = BMU_CPOP; a32 = 32'hFFFFFFFF;
      step();
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (r32 !== 32'h0) begin
         tests_failed++;
         $display("FAIL async_reset: got %h expected %h", r32, 32'h0);
      end
      rst_n = 1'b1;
      step();
      tests_run++;
      if (r32 !== 32'd32) begin
         tests_failed++;
         $display("FAIL after_async_reset: got %h expected %h", r32, 32'd32);
      end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_count();
      test_ext_perm();
      test_zbs();
      test_unlisted();
      test_xlen64();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
